multi_sqr_wave_gen: RTL

//  Multi-channel programmable square-wave generator. Each channel drives HIGH for
//  hi*TICK_DIV clocks, then LOW for lo*TICK_DIV clocks, and repeats.
//  New settings go into per-channel shadow registers. They take effect only at a

---
 rtl/multi_sqr_wave_gen_if.sv | 38 +++
 rtl/multi_sqr_wave_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/multi_sqr_wave_gen_if.sv
// Configuration/output bundle for multi_sqr_wave_gen.
//   master : drives the write port (cfg_*) and sync, observes out/period_done
//   slave  : the generator itself
// Signals:
//   cfg_we       write strobe for the shadow registers of cfg_ch
//   cfg_ch       target channel; values >= NCH are ignored by the generator
//   cfg_hi/lo    high/low durations in ticks
//   cfg_en       channel enable
//   cfg_inv      output polarity invert
//   sync         restart prescaler and all running channels
//   out          waveform outputs, one per channel
//   period_done  1-clk pulse per channel at each period end
interface multi_sqr_wave_gen_if #(
   parameter int NCH = 4,
   parameter int CW  = 8
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           cfg_we;
   logic [CHW-1:0] cfg_ch;
   logic [CW-1:0]  cfg_hi;
   logic [CW-1:0]  cfg_lo;
   logic           cfg_en;
   logic           cfg_inv;
   logic           sync;
   logic [NCH-1:0] out;
   logic [NCH-1:0] period_done;

   modport master (
      output cfg_we, cfg_ch, cfg_hi, cfg_lo, cfg_en, cfg_inv, sync,
      input  out, period_done
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_hi, cfg_lo, cfg_en, cfg_inv, sync,
      output out, period_done
   );
endinterface

// File: rtl/multi_sqr_wave_gen.sv
// Multi-channel programmable square-wave generator.
// Each channel is HIGH for hi*TICK_DIV clocks, then LOW for lo*TICK_DIV clocks,
// repeating. Settings are written into per-channel shadow registers and only
// copied into the active registers at an IDLE start, a period end or a sync,
// so reprogramming never truncates or glitches a running waveform.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  slave side of multi_sqr_wave_gen_if (cfg write port, sync, out, period_done)
module multi_sqr_wave_gen #(
   parameter int NCH      = 4,
   parameter int CW       = 8,
   parameter int TICK_DIV = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   multi_sqr_wave_gen_if.slave  bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW  = $clog2(TICK_DIV);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd1;
   localparam logic [1:0] S_LOW  = 2'd2;

   logic [PW-1:0] pre;
   logic          tick;

   // sync outranks a coincident tick, so the tick is masked here for all channels
   assign tick = (pre == PW'(TICK_DIV - 1)) && !bus.sync;

   always_ff @(posedge clk) begin
      if (rst || bus.sync) begin
         pre <= '0;
      end else if (pre == PW'(TICK_DIV - 1)) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CW-1:0] sh_hi, sh_lo;
      logic          sh_en, sh_inv;
      logic [CW-1:0] hi_a, lo_a, cnt;
      logic          inv_a;
      logic [1:0]    state;
      logic          pd;

      logic          wr, run_ok, hi_end, lo_end, pend, start, reload;
      logic [1:0]    load_state;

      // out-of-range cfg_ch never matches any g, so such writes are dropped
      assign wr     = bus.cfg_we && (bus.cfg_ch == CHW'(g));
      assign run_ok = sh_en && ((sh_hi | sh_lo) != '0);

      always_comb begin
         hi_end     = 1'b0;
         lo_end     = 1'b0;
         pend       = 1'b0;
         start      = 1'b0;
         reload     = 1'b0;
         load_state = S_IDLE;
         hi_end = (cnt == hi_a - CW'(1));
         lo_end = (cnt == lo_a - CW'(1));
         pend   = tick && (((state == S_HIGH) && hi_end && (lo_a == '0)) ||
                           ((state == S_LOW) && lo_end));
         start  = tick && (state == S_IDLE) && run_ok;
         reload = pend || start || (bus.sync && (state != S_IDLE));
         if (run_ok) begin
            load_state = (sh_hi != '0) ? S_HIGH : S_LOW;
         end
      end

      // Reload reads the pre-edge shadow, so a same-edge write lands one period later.
      always_ff @(posedge clk) begin
         if (rst) begin
            sh_hi  <= '0;
            sh_lo  <= '0;
            sh_en  <= 1'b0;
            sh_inv <= 1'b0;
            hi_a   <= '0;
            lo_a   <= '0;
            inv_a  <= 1'b0;
            cnt    <= '0;
            state  <= S_IDLE;
            pd     <= 1'b0;
         end else begin
            if (wr) begin
               sh_hi  <= bus.cfg_hi;
               sh_lo  <= bus.cfg_lo;
               sh_en  <= bus.cfg_en;
               sh_inv <= bus.cfg_inv;
            end
            pd <= pend;
            if (reload) begin
               hi_a  <= sh_hi;
               lo_a  <= sh_lo;
               inv_a <= sh_inv;
               cnt   <= '0;
               state <= load_state;
            end else begin
               case (state)
                  S_IDLE: begin
                     inv_a <= sh_inv;
                     cnt   <= '0;
                  end
                  S_HIGH: begin
                     if (tick) begin
                        if (hi_end) begin
                           cnt   <= '0;
                           state <= S_LOW;
                        end else begin
                           cnt <= cnt + CW'(1);
                        end
                     end
                  end
                  S_LOW: begin
                     if (tick) begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  default: begin
                     state <= S_IDLE;
                     cnt   <= '0;
                  end
               endcase
            end
         end
      end

      assign bus.out[g]         = (state == S_HIGH) ^ inv_a;
      assign bus.period_done[g] = pd;
   end

endmodule
